// File: rtl/wave_cfg_pkg.sv
// Shared constants and state types for the wave generator's UART configuration front end.
package wave_cfg_pkg;

    localparam logic [7:0] HDR_BYTE   = 8'hA5;

    localparam logic [7:0] CMD_WAVE   = 8'h01;
    localparam logic [7:0] CMD_FLO    = 8'h02;
    localparam logic [7:0] CMD_FHI    = 8'h03;
    localparam logic [7:0] CMD_AMP    = 8'h04;

    localparam logic [2:0] WAVE_SINE  = 3'd0;
    localparam logic [2:0] WAVE_SQUARE = 3'd1;
    localparam logic [2:0] WAVE_TRI   = 3'd2;
    localparam logic [2:0] WAVE_SAW   = 3'd3;
    localparam logic [2:0] WAVE_NOISE = 3'd4;

    typedef enum logic [1:0] {
        P_HDR  = 2'd0,
        P_CMD  = 2'd1,
        P_DATA = 2'd2,
        P_CHK  = 2'd3
    } parse_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    // Packet check byte: XOR of command and payload.
    function automatic logic [7:0] pkt_chk(input logic [7:0] cmd, input logic [7:0] data);
        return cmd ^ data;
    endfunction

endpackage

// File: rtl/wave_cfg_uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling FSM and baud/bit counters.
module uart_rx_byte
    import wave_cfg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       r_sync;
    logic             w_rx;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;
    logic             r_busy;
    logic             w_tick;
    logic             w_stop_ok;
    logic             w_stop_bad;

    assign w_rx = r_sync[1];

    // Two-flop synchronizer; preset high so reset looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // Receiver next-state and sample strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!w_rx) w_state_nxt = RX_START;
                else       w_state_nxt = RX_IDLE;
            end
            RX_START: begin
                if (r_baud_cnt == HALF_LAST) begin
                    w_tick      = 1'b1;
                    w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
                end else begin
                    w_state_nxt = RX_START;
                end
            end
            RX_DATA: begin
                if (r_baud_cnt == BIT_LAST) begin
                    w_tick      = 1'b1;
                    w_state_nxt = (r_bit_cnt == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    w_state_nxt = RX_DATA;
                end
            end
            RX_STOP: begin
                if (r_baud_cnt == BIT_LAST) begin
                    w_tick = 1'b1;
                    if (w_rx) begin
                        w_stop_ok   = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = RX_WAIT;
                    end
                end else begin
                    w_state_nxt = RX_STOP;
                end
            end
            RX_WAIT: begin
                if (w_rx) w_state_nxt = RX_IDLE;
                else      w_state_nxt = RX_WAIT;
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RX_IDLE;
            r_baud_cnt   <= {CNT_W{1'b0}};
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_valid <= w_stop_ok;
            r_frame_err  <= w_stop_bad;
            r_busy       <= (w_state_nxt != RX_IDLE);
            if (r_state == RX_IDLE || r_state == RX_WAIT || w_tick) begin
                r_baud_cnt <= {CNT_W{1'b0}};
            end else begin
                r_baud_cnt <= r_baud_cnt + CNT_W'(1);
            end
            if (r_state == RX_START) begin
                r_bit_cnt <= 3'd0;
            end else if (r_state == RX_DATA && w_tick) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_state == RX_DATA && w_tick) begin
                r_shift <= {w_rx, r_shift[7:1]};
            end
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_shift;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: rtl/wave_cfg_uart_rx.sv
// UART command front end: parses A5/cmd/data/chk packets into the wave core's configuration registers.
module wave_cfg_uart_rx
    import wave_cfg_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 87,
    parameter int          TIMEOUT_BITS = 32,
    parameter logic [15:0] FREQ_RST     = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [2:0]  wave_sel,
    output logic [15:0] freq_word,
    output logic [7:0]  amplitude,
    output logic        cfg_valid,
    output logic        err
);

    localparam int              TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int              TO_W     = $clog2(TO_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_LIMIT - 1);

    logic            w_byte_valid;
    logic [7:0]      w_byte_data;
    logic            w_frame_err;
    logic            w_busy;

    parse_state_t    r_pstate;
    parse_state_t    w_pnext;
    logic [7:0]      r_cmd;
    logic [7:0]      r_data;
    logic [7:0]      r_freq_lo;
    logic [2:0]      r_wave_sel;
    logic [15:0]     r_freq_word;
    logic [7:0]      r_amplitude;
    logic            r_cfg_valid;
    logic            r_err;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    logic            w_apply;
    logic            w_pkt_err;
    logic            w_cmd_ok;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (w_frame_err),
        .busy       (w_busy)
    );

    // The gap timer only counts while the line is idle between bytes of an open packet.
    assign w_timeout = (r_pstate != P_HDR) && !w_busy && (r_to_cnt == TO_LAST);

    // Parser next-state plus packet accept/reject decisions.
    always_comb begin
        w_pnext   = r_pstate;
        w_apply   = 1'b0;
        w_pkt_err = 1'b0;
        w_cmd_ok  = (r_cmd == CMD_WAVE) || (r_cmd == CMD_FLO) ||
                    (r_cmd == CMD_FHI)  || (r_cmd == CMD_AMP);
        if (w_frame_err) begin
            w_pnext = P_HDR;
        end else if (w_byte_valid) begin
            case (r_pstate)
                P_HDR:   w_pnext = (w_byte_data == HDR_BYTE) ? P_CMD : P_HDR;
                P_CMD:   w_pnext = P_DATA;
                P_DATA:  w_pnext = P_CHK;
                P_CHK: begin
                    w_pnext = P_HDR;
                    if ((w_byte_data == pkt_chk(r_cmd, r_data)) && w_cmd_ok) begin
                        w_apply = 1'b1;
                    end else begin
                        w_pkt_err = 1'b1;
                    end
                end
                default: w_pnext = P_HDR;
            endcase
        end else if (w_timeout) begin
            w_pnext = P_HDR;
        end else begin
            w_pnext = r_pstate;
        end
    end

    // Parser state and inter-byte gap timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pstate <= P_HDR;
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            r_pstate <= w_pnext;
            if (r_pstate == P_HDR || w_byte_valid || w_busy || w_timeout) begin
                r_to_cnt <= {TO_W{1'b0}};
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    // Packet fields, configuration registers and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd       <= 8'h00;
            r_data      <= 8'h00;
            r_freq_lo   <= 8'h00;
            r_wave_sel  <= WAVE_SINE;
            r_freq_word <= FREQ_RST;
            r_amplitude <= 8'hFF;
            r_cfg_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Staging the low byte is not a visible config change, so it never pulses cfg_valid.
            r_cfg_valid <= w_apply && (r_cmd != CMD_FLO);
            r_err       <= w_frame_err || w_pkt_err;
            if (r_pstate == P_CMD && w_byte_valid) begin
                r_cmd <= w_byte_data;
            end
            if (r_pstate == P_DATA && w_byte_valid) begin
                r_data <= w_byte_data;
            end
            if (w_apply) begin
                case (r_cmd)
                    CMD_WAVE: r_wave_sel  <= r_data[2:0];
                    CMD_FLO:  r_freq_lo   <= r_data;
                    CMD_FHI:  r_freq_word <= {r_data, r_freq_lo};
                    CMD_AMP:  r_amplitude <= r_data;
                    default:  r_amplitude <= r_amplitude;
                endcase
            end
        end
    end

    assign wave_sel  = r_wave_sel;
    assign freq_word = r_freq_word;
    assign amplitude = r_amplitude;
    assign cfg_valid = r_cfg_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_wave_cfg_uart_rx.sv
// Directed plus randomized bench for wave_cfg_uart_rx against a packet-level reference model.
module tb_wave_cfg_uart_rx;

    localparam int CPB = 4;
    localparam int TOB = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic [2:0]  wave_sel;
    logic [15:0] freq_word;
    logic [7:0]  amplitude;
    logic        cfg_valid;
    logic        err;

    wave_cfg_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TOB),
        .FREQ_RST     (16'h0100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .wave_sel  (wave_sel),
        .freq_word (freq_word),
        .amplitude (amplitude),
        .cfg_valid (cfg_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge.
    int          cfg_cnt = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    int          freq_chg = 0;
    int          last_cfg_cyc = -1000;
    logic [15:0] prev_freq = 16'h0000;
    always @(negedge clk) begin
        if (cfg_valid === 1'b1) begin
            cfg_cnt++;
            last_cfg_cyc = cyc;
        end
        if (err === 1'b1) err_cnt++;
        if (cfg_valid === 1'b1 && err === 1'b1) both_cnt++;
        if (freq_word !== prev_freq) freq_chg++;
        prev_freq = freq_word;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: collects bytes into a packet buffer, acting on complete packets.
    logic [7:0]  mq[$];
    logic [2:0]  m_wave;
    logic [15:0] m_freq;
    logic [7:0]  m_amp;
    logic [7:0]  m_lo;
    int          m_cfg = 0;
    int          m_err = 0;

    task automatic model_reset();
        mq.delete();
        m_wave = 3'd0;
        m_freq = 16'h0100;
        m_amp  = 8'hFF;
        m_lo   = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (mq.size() == 0 && b != 8'hA5) return;
        mq.push_back(b);
        if (mq.size() == 4) begin
            if (mq[3] != (mq[1] ^ mq[2])) begin
                m_err++;
            end else if (mq[1] == 8'h01) begin
                m_wave = mq[2][2:0];
                m_cfg++;
            end else if (mq[1] == 8'h02) begin
                m_lo = mq[2];
            end else if (mq[1] == 8'h03) begin
                m_freq = {mq[2], m_lo};
                m_cfg++;
            end else if (mq[1] == 8'h04) begin
                m_amp = mq[2];
                m_cfg++;
            end else begin
                m_err++;
            end
            mq.delete();
        end
    endtask

    int stop_cyc = 0;

    // Called on a falling edge; returns on a falling edge with the line high.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        stop_cyc = cyc;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_model(input logic [7:0] b, input int gap);
        send_byte(b, 1'b1);
        model_byte(b);
        idle(gap);
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] d, input logic [7:0] s);
        send_model(8'hA5, $urandom_range(0, 3));
        send_model(c,     $urandom_range(0, 3));
        send_model(d,     $urandom_range(0, 3));
        send_model(s,     0);
    endtask

    task automatic check_all(input string tag);
        idle(4);
        check({tag, ".wave"}, 32'(wave_sel),  32'(m_wave));
        check({tag, ".freq"}, 32'(freq_word), 32'(m_freq));
        check({tag, ".amp"},  32'(amplitude), 32'(m_amp));
        check({tag, ".cfgn"}, 32'(cfg_cnt),   32'(m_cfg));
        check({tag, ".errn"}, 32'(err_cnt),   32'(m_err));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          f0;
    logic [7:0]  rc, rd, rs, stray;

    initial begin
        // 1: reset release with idle line
        model_reset();
        idle(5);
        rst_n = 1'b1;
        idle(500);
        check_all("reset");

        // 2: waveform select and latency of cfg_valid
        send_pkt(8'h01, 8'h03, 8'h02);
        idle(6);
        check("wave_lat", 32'(last_cfg_cyc - stop_cyc >= CPB / 2 + 2 && last_cfg_cyc - stop_cyc <= CPB + 3), 32'd1);
        check_all("wave3");

        // 3: staged low byte then atomic high-byte commit
        f0 = freq_chg;
        send_pkt(8'h02, 8'h34, 8'h36);
        check_all("flo");
        check("flo_nochg", 32'(freq_chg), 32'(f0));
        send_pkt(8'h03, 8'h12, 8'h11);
        check_all("fhi");
        check("fhi_1chg", 32'(freq_chg), 32'(f0 + 1));

        // 4: bad checksum then good amplitude
        send_pkt(8'h04, 8'h80, 8'h00);
        check_all("badchk");
        send_pkt(8'h04, 8'h80, 8'h84);
        check_all("amp80");

        // 5: stray byte, partial packet, timeout discard
        send_model(8'h00, 2);
        send_model(8'hA5, 2);
        send_model(8'h01, 0);
        idle(16 * CPB + 16);
        mq.delete();
        send_pkt(8'h01, 8'h02, 8'h03);
        check_all("timeout");

        // 6: framing error inside a packet, then unknown command
        send_model(8'hA5, 1);
        send_byte(8'h5A, 1'b0);
        mq.delete();
        m_err++;
        idle(8);
        check_all("frame");
        send_pkt(8'h09, 8'h00, 8'h09);
        check_all("unkcmd");

        // Asynchronous reset in the middle of a byte
        rx = 1'b0;
        idle(10);
        #2 rst_n = 1'b0;
        #1;
        check("arst.wave", 32'(wave_sel),  32'd0);
        check("arst.freq", 32'(freq_word), 32'h0100);
        check("arst.amp",  32'(amplitude), 32'hFF);
        check("arst.cfg",  32'(cfg_valid), 32'd0);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        model_reset();
        idle(5);
        send_pkt(8'h03, 8'h56, 8'h55);
        check_all("lo_cleared");

        // Randomized packets with occasional stray bytes and corrupted checksums
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                stray = 8'($urandom);
                if (stray == 8'hA5) stray = 8'h00;
                send_model(stray, $urandom_range(0, 3));
            end
            rc = 8'($urandom_range(1, 5));
            if ($urandom_range(0, 7) == 0) rc = 8'($urandom);
            rd = 8'($urandom);
            rs = rc ^ rd;
            if ($urandom_range(0, 3) == 0) rs = rs ^ 8'(1 << $urandom_range(0, 7));
            send_pkt(rc, rd, rs);
            check_all("rand");
        end

        check("exclusive", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
